sd_cmd_frame_tx: RTL and testbench

Builds the 48-bit SD command token (start bit, transmission bit, index, argument, CRC7, end bit) and sequences the downstream parallel-to-serial stage (N=48) that drives the CMD pad. CRC7 is computed serially, one bit per sd_clock, so no wide XOR tree is needed. Sits between the command control FSM (req/done/error handshake) and the CMD serializer (parallel/enable/load_send/complete).

---
 rtl/sd_cmd_frame_tx.sv | 138 +++++++++++++
 tb/tb_sd_cmd_frame_tx.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/sd_cmd_frame_tx.sv
// SD command token builder: assembles start/tx/index/arg/CRC7/end into a 48-bit
// frame, computing CRC7 one bit per clock, then hands it to the CMD serializer.
module sd_cmd_frame_tx #(
    parameter int FRAME_W = 48,
    parameter int TIMEOUT = 64
) (
    input  logic               sd_clock,
    input  logic               reset,
    input  logic               cmd_start,
    input  logic [5:0]         cmd_index,
    input  logic [31:0]        cmd_arg,
    output logic               cmd_busy,
    output logic               cmd_done,
    output logic               cmd_error,
    output logic [6:0]         crc_out,
    output logic [FRAME_W-1:0] frame,
    output logic               ser_enable,
    output logic               ser_load_send,
    input  logic               ser_complete
);

    // state | meaning
    // IDLE  | waiting for cmd_start
    // CRC   | shifting 40 header bits through CRC7, one per clock
    // LOAD  | frame valid, one-cycle serializer load strobe
    // SEND  | serializer transmitting, waiting for ser_complete or timeout
    // DONE  | one-cycle completion pulse
    // ERR   | one-cycle timeout pulse
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CRC  = 3'd1,
        S_LOAD = 3'd2,
        S_SEND = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    localparam logic [5:0] LAST_BIT = 6'd39;
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [39:0]         shift_q, shift_d;
    logic [6:0]          crc_q, crc_d;
    logic [5:0]          bit_cnt_q, bit_cnt_d;
    logic [7:0]          tmo_q, tmo_d;
    logic [FRAME_W-1:0]  frame_q, frame_d;
    logic [6:0]          crc_out_q, crc_out_d;

    logic                crc_fb;
    logic [6:0]          crc_step;
    logic [39:0]         shift_rot;
    logic                first_send;

    assign crc_fb     = shift_q[39] ^ crc_q[6];
    assign crc_step   = {crc_q[5:0], 1'b0} ^ (crc_fb ? 7'h09 : 7'h00);
    // Rotating instead of shifting restores the header after 40 steps.
    assign shift_rot  = {shift_q[38:0], shift_q[39]};
    // Down-counter still at its load value means this is the first SEND cycle.
    assign first_send = (tmo_q == TMO_LAST);

    always_ff @(posedge sd_clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            crc_q     <= '0;
            bit_cnt_q <= '0;
            tmo_q     <= '0;
            frame_q   <= '0;
            crc_out_q <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            crc_q     <= crc_d;
            bit_cnt_q <= bit_cnt_d;
            tmo_q     <= tmo_d;
            frame_q   <= frame_d;
            crc_out_q <= crc_out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (cmd_start) state_d = S_CRC;
            S_CRC:  if (bit_cnt_q == LAST_BIT) state_d = S_LOAD;
            S_LOAD: state_d = S_SEND;
            S_SEND: begin
                if (ser_complete && !first_send) state_d = S_DONE;
                else if (tmo_q == 8'd0)          state_d = S_ERR;
            end
            S_DONE: state_d = S_IDLE;
            S_ERR:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        shift_d   = shift_q;
        crc_d     = crc_q;
        bit_cnt_d = bit_cnt_q;
        tmo_d     = tmo_q;
        frame_d   = frame_q;
        crc_out_d = crc_out_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_start) begin
                    shift_d   = {2'b01, cmd_index, cmd_arg};
                    crc_d     = '0;
                    bit_cnt_d = '0;
                end
            end
            S_CRC: begin
                shift_d   = shift_rot;
                crc_d     = crc_step;
                bit_cnt_d = bit_cnt_q + 6'd1;
                if (bit_cnt_q == LAST_BIT) begin
                    frame_d   = {shift_rot, crc_step, 1'b1};
                    crc_out_d = crc_step;
                end
            end
            S_LOAD: tmo_d = TMO_LAST;
            S_SEND: if (tmo_q != 8'd0) tmo_d = tmo_q - 8'd1;
            default: ;
        endcase
    end

    always_comb begin
        cmd_busy      = (state_q != S_IDLE);
        cmd_done      = (state_q == S_DONE);
        cmd_error     = (state_q == S_ERR);
        ser_enable    = (state_q == S_LOAD);
        ser_load_send = (state_q == S_SEND);
    end

    assign frame   = frame_q;
    assign crc_out = crc_out_q;

endmodule

// File: tb/tb_sd_cmd_frame_tx.sv
// Directed bench for sd_cmd_frame_tx: known CMD tokens, timeout, masking,
// ignored restarts and mid-frame reset.
module tb_sd_cmd_frame_tx;

    logic        sd_clock = 1'b0;
    logic        reset;
    logic        cmd_start;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        cmd_busy, cmd_done, cmd_error;
    logic [6:0]  crc_out;
    logic [47:0] frame;
    logic        ser_enable, ser_load_send, ser_complete;

    int checks   = 0;
    int failures = 0;

    sd_cmd_frame_tx dut (
        .sd_clock      (sd_clock),
        .reset         (reset),
        .cmd_start     (cmd_start),
        .cmd_index     (cmd_index),
        .cmd_arg       (cmd_arg),
        .cmd_busy      (cmd_busy),
        .cmd_done      (cmd_done),
        .cmd_error     (cmd_error),
        .crc_out       (crc_out),
        .frame         (frame),
        .ser_enable    (ser_enable),
        .ser_load_send (ser_load_send),
        .ser_complete  (ser_complete)
    );

    always #5 sd_clock = ~sd_clock;

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // complete_at: SEND cycle index (0-based) at which ser_complete is driven, -1 for never.
    // stale: ser_complete high in SEND cycle 0 only. mid_crc/mid_send: extra cmd_start pulses.
    task automatic run_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                           input int complete_at, input bit stale,
                           input bit mid_crc, input bit mid_send,
                           input logic [47:0] exp_frame, input logic [6:0] exp_crc,
                           input bit exp_done, input int exp_send_cycles);
        int cyc;
        int k;
        bit ls_ok;
        int done_cnt;
        cmd_start = 1'b1;
        cmd_index = idx;
        cmd_arg   = arg;
        @(negedge sd_clock);
        cmd_start = 1'b0;
        cmd_index = ~idx;
        cmd_arg   = ~arg;
        chk({tag, "_busy_crc"}, 48'(cmd_busy), 48'd1);
        cyc = 1;
        while (!ser_enable && cyc < 100) begin
            cmd_start = mid_crc && (cyc == 20);
            if (cmd_start) cmd_index = 6'd55;
            @(negedge sd_clock);
            cyc++;
        end
        cmd_start = 1'b0;
        chk({tag, "_load_cycle"}, 48'(cyc), 48'd41);
        chk({tag, "_frame"}, frame, exp_frame);
        chk({tag, "_crc"}, 48'(crc_out), 48'(exp_crc));
        @(negedge sd_clock);
        chk({tag, "_enable_1cyc"}, 48'(ser_enable), 48'd0);
        k = 0;
        ls_ok = 1'b1;
        done_cnt = 0;
        while (k < 200) begin
            if (cmd_done || cmd_error) break;
            if (!ser_load_send) ls_ok = 1'b0;
            ser_complete = (k == complete_at) || (stale && k == 0);
            cmd_start = mid_send && (k == 10);
            if (cmd_start) cmd_index = 6'd17;
            @(negedge sd_clock);
            k++;
        end
        ser_complete = 1'b0;
        cmd_start = 1'b0;
        chk({tag, "_send_cycles"}, 48'(k), 48'(exp_send_cycles));
        chk({tag, "_load_send_held"}, 48'(ls_ok), 48'd1);
        chk({tag, "_done"}, 48'(cmd_done), 48'(exp_done));
        chk({tag, "_error"}, 48'(cmd_error), 48'(!exp_done));
        chk({tag, "_load_send_off"}, 48'(ser_load_send), 48'd0);
        chk({tag, "_busy_end"}, 48'(cmd_busy), 48'd1);
        chk({tag, "_frame_kept"}, frame, exp_frame);
        if (cmd_done) done_cnt++;
        @(negedge sd_clock);
        if (cmd_done) done_cnt++;
        chk({tag, "_busy_idle"}, 48'(cmd_busy), 48'd0);
        chk({tag, "_pulse_1cyc"}, 48'(cmd_done | cmd_error), 48'd0);
        chk({tag, "_done_count"}, 48'(done_cnt), 48'(exp_done));
    endtask

    initial begin
        reset        = 1'b1;
        cmd_start    = 1'b0;
        cmd_index    = '0;
        cmd_arg      = '0;
        ser_complete = 1'b0;
        repeat (3) @(negedge sd_clock);
        chk("rst_frame", frame, 48'd0);
        chk("rst_outs", 48'({cmd_busy, cmd_done, cmd_error, ser_enable, ser_load_send, crc_out}), 48'd0);
        reset = 1'b0;
        @(negedge sd_clock);

        run_cmd("cmd0", 6'd0, 32'h0, 47, 0, 0, 0, 48'h40_0000_0000_95, 7'h4A, 1, 48);
        run_cmd("cmd8", 6'd8, 32'h1AA, 5, 0, 0, 0, 48'h48_0000_01AA_87, 7'h43, 1, 6);
        run_cmd("cmd17", 6'd17, 32'h0, 1, 0, 0, 0, 48'h51_0000_0000_55, 7'h2A, 1, 2);
        run_cmd("restart", 6'd8, 32'h1AA, 30, 0, 1, 1, 48'h48_0000_01AA_87, 7'h43, 1, 31);
        run_cmd("timeout", 6'd17, 32'h0, -1, 0, 0, 0, 48'h51_0000_0000_55, 7'h2A, 0, 64);
        run_cmd("stale", 6'd0, 32'h0, -1, 1, 0, 0, 48'h40_0000_0000_95, 7'h4A, 0, 64);
        run_cmd("tie", 6'd8, 32'h1AA, 63, 0, 0, 0, 48'h48_0000_01AA_87, 7'h43, 1, 64);

        cmd_start = 1'b1;
        cmd_index = 6'd17;
        cmd_arg   = 32'h1234_5678;
        @(negedge sd_clock);
        cmd_start = 1'b0;
        repeat (20) @(negedge sd_clock);
        reset = 1'b1;
        @(negedge sd_clock);
        chk("midrst_frame", frame, 48'd0);
        chk("midrst_outs", 48'({cmd_busy, cmd_done, cmd_error, ser_enable, ser_load_send, crc_out}), 48'd0);
        reset = 1'b0;
        @(negedge sd_clock);
        run_cmd("after_rst", 6'd0, 32'h0, 3, 0, 0, 0, 48'h40_0000_0000_95, 7'h4A, 1, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
